// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               iterative rotation-mode CORDIC (polar -> rectangular).
//               - ITER_DEF / IW_DEF : default iteration count / datapath width
//               - ZW                : angle accumulator width (1/25600 degree)
//               - K_INV / K_SHIFT   : CORDIC gain compensation, Q15
//               - atan_lut()        : round(atan(2^-i) * 180/pi * 25600)
//               - sat16()           : saturate a wide signed value to 16 bits
// Revision    : 1.0  initial release
// ============================================================================
package cordic_pkg;

  localparam int ITER_DEF = 16;
  localparam int IW_DEF   = 20;
  localparam int ZW       = 24;

  // 19898 / 32768 ~= 0.60725, inverse of the accumulated micro-rotation gain
  localparam logic [15:0] K_INV   = 16'd19898;
  localparam int          K_SHIFT = 15;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ITER  = S_ITER,
    ST_SCALE = S_SCALE,
    ST_DONE  = S_DONE
  } fsm_state_e;

  // Elementary rotation angles in units of 1/25600 degree
  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] idx);
    logic signed [ZW-1:0] v;
    case (idx)
      4'd0:    v = 24'sd1152000;
      4'd1:    v = 24'sd680065;
      4'd2:    v = 24'sd359328;
      4'd3:    v = 24'sd182400;
      4'd4:    v = 24'sd91554;
      4'd5:    v = 24'sd45822;
      4'd6:    v = 24'sd22916;
      4'd7:    v = 24'sd11459;
      4'd8:    v = 24'sd5730;
      4'd9:    v = 24'sd2865;
      4'd10:   v = 24'sd1432;
      4'd11:   v = 24'sd716;
      4'd12:   v = 24'sd358;
      4'd13:   v = 24'sd179;
      4'd14:   v = 24'sd90;
      default: v = 24'sd45;
    endcase
    return v;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    logic signed [15:0] s;
    if (v > 64'sd32767)
      s = 16'sh7fff;
    else if (v < -64'sd32768)
      s = 16'sh8000;
    else
      s = v[15:0];
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_micro_rot.sv
`default_nettype none
// ============================================================================
// Module      : cordic_micro_rot
// Description : One combinational rotation-mode CORDIC micro-rotation.
//               Rotates (x,y) towards driving the residual angle z to zero.
// Ports       : x_in, y_in  - IW-bit signed vector components
//               z_in        - ZW-bit signed residual angle (1/25600 degree)
//               idx         - iteration index i (shift amount, atan select)
//               x_nxt/y_nxt/z_nxt - rotated vector and updated residual
// Revision    : 1.0  initial release
// ============================================================================
module cordic_micro_rot
  import cordic_pkg::*;
#(
  parameter int IW = IW_DEF
) (
  input  logic signed [IW-1:0] x_in,
  input  logic signed [IW-1:0] y_in,
  input  logic signed [ZW-1:0] z_in,
  input  logic        [3:0]    idx,
  output logic signed [IW-1:0] x_nxt,
  output logic signed [IW-1:0] y_nxt,
  output logic signed [ZW-1:0] z_nxt
);

  logic signed [IW-1:0] w_xs;
  logic signed [IW-1:0] w_ys;
  logic signed [ZW-1:0] w_atan;

  always_comb begin
    w_xs   = x_in >>> idx;
    w_ys   = y_in >>> idx;
    w_atan = atan_lut(idx);
    // d = +1 when the residual angle is non-negative
    if (!z_in[ZW-1]) begin
      x_nxt = x_in - w_ys;
      y_nxt = y_in + w_xs;
      z_nxt = z_in - w_atan;
    end else begin
      x_nxt = x_in + w_ys;
      y_nxt = y_in - w_xs;
      z_nxt = z_in + w_atan;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rot_mode_seq.sv
`default_nettype none
// ============================================================================
// Module      : rot_mode_seq
// Description : Sequential rotation-mode CORDIC, polar -> rectangular.
//               One micro-rotation per clock, gain-compensated and
//               saturated to 16-bit results, valid/ready on both sides.
// Ports       : clk, rst (async, active low)
//               in_valid/in_ready, r_in (signed magnitude), angle_in
//               (signed, 0.01 degree), out_valid/out_ready,
//               x_out = r*cos(angle), y_out = r*sin(angle)
// Revision    : 1.0  initial release
// ============================================================================
module rot_mode_seq
  import cordic_pkg::*;
#(
  parameter int ITER = ITER_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] r_in,
  input  logic signed [15:0] angle_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] x_out,
  output logic signed [15:0] y_out
);

  // Of the guard bits above the 16 data bits, all but one carry fraction;
  // the remaining one absorbs the ~1.647 CORDIC growth.
  localparam int C_FRAC = IW - 17;
  localparam int C_SH   = K_SHIFT + C_FRAC;
  localparam int PW     = IW + 17;

  localparam logic signed [PW-1:0] C_HALF = PW'(1) <<< (C_SH - 1);
  localparam logic signed [15:0]   C_AMAX = 16'sd18000;
  localparam logic signed [15:0]   C_AQTR = 16'sd9000;
  localparam logic        [3:0]    C_LAST = 4'(ITER - 1);

  fsm_state_e           r_state;
  logic                 r_armed;
  logic [3:0]           r_cnt;
  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_y;
  logic signed [ZW-1:0] r_z;
  logic signed [15:0]   r_xo;
  logic signed [15:0]   r_yo;

  logic signed [15:0]   w_r;
  logic signed [15:0]   w_ang;
  logic signed [15:0]   w_zang;
  logic signed [IW-1:0] w_rx;
  logic signed [IW-1:0] w_x0;
  logic signed [IW-1:0] w_y0;
  logic signed [ZW-1:0] w_z0;
  logic signed [IW-1:0] w_xn;
  logic signed [IW-1:0] w_yn;
  logic signed [ZW-1:0] w_zn;
  logic signed [PW-1:0] w_k;
  logic signed [PW-1:0] w_px;
  logic signed [PW-1:0] w_py;
  logic signed [PW-1:0] w_qx;
  logic signed [PW-1:0] w_qy;

  // in_ready is held low until the first edge after reset release
  assign in_ready  = (r_state == ST_IDLE) && r_armed;
  assign out_valid = (r_state == ST_DONE);
  assign x_out     = r_xo;
  assign y_out     = r_yo;

  // Operand conditioning and quadrant pre-rotation
  always_comb begin
    // -32768 has no positive counterpart; fold it onto -32767
    w_r = (r_in == 16'sh8000) ? 16'sh8001 : r_in;

    if (angle_in > C_AMAX)
      w_ang = C_AMAX;
    else if (angle_in < -C_AMAX)
      w_ang = -C_AMAX;
    else
      w_ang = angle_in;

    w_rx   = {{(IW - 16 - C_FRAC){w_r[15]}}, w_r, {C_FRAC{1'b0}}};
    w_x0   = w_rx;
    w_y0   = '0;
    w_zang = w_ang;
    // Angles beyond +-90 deg start from the +-y axis so the residual stays
    // inside the CORDIC convergence range
    if (w_ang > C_AQTR) begin
      w_x0   = '0;
      w_y0   = w_rx;
      w_zang = w_ang - C_AQTR;
    end else if (w_ang < -C_AQTR) begin
      w_x0   = '0;
      w_y0   = -w_rx;
      w_zang = w_ang + C_AQTR;
    end
    w_z0 = {w_zang, 8'h00};
  end

  cordic_micro_rot #(
    .IW (IW)
  ) u_micro_rot (
    .x_in  (r_x),
    .y_in  (r_y),
    .z_in  (r_z),
    .idx   (r_cnt),
    .x_nxt (w_xn),
    .y_nxt (w_yn),
    .z_nxt (w_zn)
  );

  // Gain compensation with round-half-up, dropping the fraction bits too
  always_comb begin
    w_k  = PW'($signed({1'b0, K_INV}));
    w_px = PW'(r_x) * w_k;
    w_py = PW'(r_y) * w_k;
    w_qx = (w_px + C_HALF) >>> C_SH;
    w_qy = (w_py + C_HALF) >>> C_SH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_xo    <= '0;
      r_yo    <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_z     <= w_z0;
            r_cnt   <= '0;
            r_state <= ST_ITER;
          end
        end
        ST_ITER: begin
          r_x <= w_xn;
          r_y <= w_yn;
          r_z <= w_zn;
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_SCALE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_SCALE: begin
          r_xo    <= sat16(64'(w_qx));
          r_yo    <= sat16(64'(w_qy));
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_valid && out_ready)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rot_mode_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rot_mode_seq
// Description : Self-checking bench for rot_mode_seq. Expected results come
//               from real-valued trigonometry on the clamped operands.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rot_mode_seq;

  localparam int  ITER = 16;
  localparam real PI   = 3.14159265358979;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] r_in;
  logic signed [15:0] angle_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;

  int n_chk;
  int n_pass;

  rot_mode_seq #(
    .ITER (ITER),
    .IW   (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: r*cos / r*sin of the clamped operands, rounded and saturated
  function automatic int model(input int r, input int a, input bit want_y);
    real rr;
    real ar;
    real v;
    int  e;
    if (r == -32768) r = -32767;
    if (a > 18000) a = 18000;
    else if (a < -18000) a = -18000;
    rr = real'(r);
    ar = (real'(a) / 100.0) * PI / 180.0;
    v  = want_y ? rr * $sin(ar) : rr * $cos(ar);
    e  = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    if (e > 32767) e = 32767;
    if (e < -32768) e = -32768;
    return e;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input int exp, input int tol);
    int d;
    d = int'(obs) - exp;
    if (d < 0) d = -d;
    n_chk++;
    assert (!$isunknown(obs) && (d <= tol)) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Entered and left on a falling edge. bp = cycles of withheld out_ready.
  task automatic do_op(input int r, input int a, input int bp, input int tol);
    int guard;
    int edges;
    logic signed [15:0] hx;
    logic signed [15:0] hy;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_op", in_ready, 1, 0);
    in_valid = 1'b1;
    r_in     = 16'(r);
    angle_in = 16'(a);
    @(negedge clk);
    // operands must have been captured; scramble the bus afterwards
    in_valid = 1'b0;
    r_in     = 16'($urandom);
    angle_in = 16'($urandom);
    chk("ready_low_busy", in_ready, 0, 0);
    // the acceptance edge is edge 1
    edges = 1;
    while (out_valid !== 1'b1 && edges < 60) begin
      @(negedge clk);
      edges++;
    end
    chk("latency_edges", edges, ITER + 2, 0);
    chk("x_out", x_out, model(r, a, 1'b0), tol);
    chk("y_out", y_out, model(r, a, 1'b1), tol);
    hx = x_out;
    hy = y_out;
    for (int k = 0; k < bp; k++) begin
      in_valid = 1'b1;
      r_in     = 16'($urandom);
      angle_in = 16'($urandom);
      @(negedge clk);
      chk("bp_x_hold", x_out, int'(hx), 0);
      chk("bp_y_hold", y_out, int'(hy), 0);
      chk("bp_valid_hold", out_valid, 1, 0);
      chk("bp_ready_low", in_ready, 0, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0, 0);
    chk("ready_after_pop", in_ready, 1, 0);
  endtask

  initial begin
    int r;
    int a;
    logic signed [15:0] ta;
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    r_in      = '0;
    angle_in  = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0, 0);
    chk("rst_out_valid", out_valid, 0, 0);
    chk("rst_x_out", x_out, 0, 0);
    chk("rst_y_out", y_out, 0, 0);
    rst = 1'b1;
    #1;
    chk("ready_before_edge", in_ready, 0, 0);
    @(negedge clk);
    chk("ready_first_edge", in_ready, 1, 0);

    // directed points
    do_op(400, 9000, 0, 2);
    do_op(500, 5313, 0, 2);
    do_op(1000, -13500, 0, 2);
    do_op(400, 20000, 0, 2);
    do_op(400, -20000, 0, 2);
    do_op(-1234, 18000, 0, 2);
    do_op(-32768, 9000, 0, 3);
    do_op(32767, 0, 0, 3);

    // backpressure
    do_op(300, 4500, 5, 2);

    // reset in the middle of the iterations
    in_valid = 1'b1;
    r_in     = 16'sd1234;
    angle_in = 16'sd3000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0, 0);
    chk("abort_in_ready", in_ready, 0, 0);
    chk("abort_x_out", x_out, 0, 0);
    chk("abort_y_out", y_out, 0, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_valid", out_valid, 0, 0);
    rst = 1'b1;
    #1;
    chk("abort_ready_wait", in_ready, 0, 0);
    @(negedge clk);
    chk("abort_ready_rise", in_ready, 1, 0);
    chk("abort_still_no_valid", out_valid, 0, 0);
    do_op(300, 0, 0, 2);

    // randomized operands within the accuracy envelope, full angle range
    for (int k = 0; k < 16; k++) begin
      r  = int'($urandom_range(32000)) - 16000;
      ta = 16'($urandom);
      a  = int'(ta);
      do_op(r, a, int'($urandom_range(2)), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
